// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/readback BIST sequencer for a single-port RAM.
// Writes a selectable pattern to every address, reads it back and reports mismatch statistics.
module ram_bist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_pattern,
  input  logic [DATA_W-1:0] i_fill_val,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_din,
  input  logic [DATA_W-1:0] i_dout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ADDR_W:0]   o_err_cnt,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int DL_N    = (RD_LAT == 0) ? 1 : RD_LAT;
  localparam int DL_LAST = (RD_LAT == 0) ? 0 : RD_LAT - 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [1:0]        DRAIN_LAST = 2'(DL_LAST);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Checkerboard puts 1s on even bit positions for even addresses, odd positions for odd ones.
  function automatic logic [DATA_W-1:0] f_pattern(input logic [1:0]        pat,
                                                  input logic [DATA_W-1:0] fill,
                                                  input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = {DATA_W{1'b0}};
    case (pat)
      2'd0:    v = DATA_W'(a);
      2'd1:    v = ~DATA_W'(a);
      2'd2:    v = fill;
      2'd3:    for (int i = 0; i < DATA_W; i++) v[i] = (a[0] == i[0]);
      default: v = {DATA_W{1'b0}};
    endcase
    return v;
  endfunction

  state_t              r_state;
  logic [1:0]          r_pat;
  logic [DATA_W-1:0]   r_fill;
  logic [1:0]          r_drain_cnt;
  logic                r_dl_vld  [DL_N];
  logic [ADDR_W-1:0]   r_dl_addr [DL_N];
  logic [DATA_W-1:0]   r_dl_exp  [DL_N];

  logic                w_in_vld;
  logic [ADDR_W-1:0]   w_in_addr;
  logic [DATA_W-1:0]   w_in_exp;
  logic                w_cmp_vld;
  logic [ADDR_W-1:0]   w_cmp_addr;
  logic [DATA_W-1:0]   w_cmp_exp;
  logic                w_mismatch;
  logic [ADDR_W:0]     w_err_cnt_nxt;
  logic [ADDR_W-1:0]   w_first_nxt;

  // Compare the entry emerging from the delay line against the RAM read data.
  always_comb begin
    w_in_vld   = (r_state == S_READ);
    w_in_addr  = o_addr;
    w_in_exp   = f_pattern(r_pat, r_fill, o_addr);
    if (RD_LAT == 0) begin
      w_cmp_vld  = w_in_vld;
      w_cmp_addr = w_in_addr;
      w_cmp_exp  = w_in_exp;
    end else begin
      w_cmp_vld  = r_dl_vld[DL_LAST];
      w_cmp_addr = r_dl_addr[DL_LAST];
      w_cmp_exp  = r_dl_exp[DL_LAST];
    end
    w_mismatch    = w_cmp_vld && (i_dout != w_cmp_exp);
    w_err_cnt_nxt = o_err_cnt + {{ADDR_W{1'b0}}, w_mismatch};
    if (w_mismatch && (o_err_cnt == {(ADDR_W+1){1'b0}})) begin
      w_first_nxt = w_cmp_addr;
    end else begin
      w_first_nxt = o_first_err_addr;
    end
  end

  // Expected-data delay line, matched to the RAM read latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DL_N; i++) begin
        r_dl_vld[i]  <= 1'b0;
        r_dl_addr[i] <= {ADDR_W{1'b0}};
        r_dl_exp[i]  <= {DATA_W{1'b0}};
      end
    end else begin
      r_dl_vld[0]  <= w_in_vld;
      r_dl_addr[0] <= w_in_addr;
      r_dl_exp[0]  <= w_in_exp;
      for (int i = 1; i < DL_N; i++) begin
        r_dl_vld[i]  <= r_dl_vld[i-1];
        r_dl_addr[i] <= r_dl_addr[i-1];
        r_dl_exp[i]  <= r_dl_exp[i-1];
      end
    end
  end

  // Test sequencer with registered RAM controls and result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_pat            <= 2'd0;
      r_fill           <= {DATA_W{1'b0}};
      r_drain_cnt      <= 2'd0;
      o_we             <= 1'b0;
      o_addr           <= {ADDR_W{1'b0}};
      o_din            <= {DATA_W{1'b0}};
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_err_cnt        <= {(ADDR_W+1){1'b0}};
      o_first_err_addr <= {ADDR_W{1'b0}};
    end else begin
      o_done           <= 1'b0;
      o_err_cnt        <= w_err_cnt_nxt;
      o_first_err_addr <= w_first_nxt;
      case (r_state)
        S_IDLE: begin
          o_we <= 1'b0;
          if (i_start) begin
            r_pat            <= i_pattern;
            r_fill           <= i_fill_val;
            o_err_cnt        <= {(ADDR_W+1){1'b0}};
            o_first_err_addr <= {ADDR_W{1'b0}};
            o_pass           <= 1'b0;
            o_busy           <= 1'b1;
            o_we             <= 1'b1;
            o_addr           <= {ADDR_W{1'b0}};
            o_din            <= f_pattern(i_pattern, i_fill_val, {ADDR_W{1'b0}});
            r_state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (o_addr == ADDR_LAST) begin
            o_we    <= 1'b0;
            o_addr  <= {ADDR_W{1'b0}};
            o_din   <= {DATA_W{1'b0}};
            r_state <= S_READ;
          end else begin
            o_addr <= o_addr + ADDR_ONE;
            o_din  <= f_pattern(r_pat, r_fill, o_addr + ADDR_ONE);
          end
        end
        S_READ: begin
          if (o_addr == ADDR_LAST) begin
            r_drain_cnt <= 2'd0;
            if (RD_LAT == 0) begin
              o_done  <= 1'b1;
              o_pass  <= (w_err_cnt_nxt == {(ADDR_W+1){1'b0}});
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            o_addr <= o_addr + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            o_done  <= 1'b1;
            o_pass  <= (w_err_cnt_nxt == {(ADDR_W+1){1'b0}});
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_we    <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: three ram_bist_ctrl builds (RD_LAT 1, 0, 3) against behavioural RAMs with
// injectable read faults; results and timing checked against a pattern/fault model.
`timescale 1ns/1ps
module tb_ram_bist_ctrl;

  localparam int NI = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [1:0] pattern;
  logic [3:0] fill;
  logic [15:0] bad_mask;
  logic        bad_zero;

  wire [NI-1:0]      we, busy, done, pass;
  wire [NI-1:0][3:0] addr, din, dout, first;
  wire [NI-1:0][4:0] errc;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L  = lat_of(g);
    localparam int PI = (L == 0) ? 0 : L - 1;
    logic [3:0] mem  [16];
    logic [3:0] pipe [4];
    logic [3:0] wlog [16];
    int         wn   [16] = '{default: 0};
    logic [3:0] rd_now;

    assign rd_now  = bad_mask[addr[g]] ? (bad_zero ? 4'h0 : ~mem[addr[g]]) : mem[addr[g]];
    assign dout[g] = (L == 0) ? rd_now : pipe[PI];

    always @(posedge clk) begin
      if (we[g]) begin
        mem[addr[g]]  <= din[g];
        wlog[addr[g]] <= din[g];
        wn[addr[g]]   <= wn[addr[g]] + 1;
      end
      pipe[0] <= rd_now;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    ram_bist_ctrl #(.ADDR_W(4), .DATA_W(4), .RD_LAT(L)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pattern(pattern), .i_fill_val(fill),
      .o_we(we[g]), .o_addr(addr[g]), .o_din(din[g]), .i_dout(dout[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_pass(pass[g]),
      .o_err_cnt(errc[g]), .o_first_err_addr(first[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Value the RAM should hold at address n for a given pattern.
  function automatic int model_pat(input int p, input int f, input int n);
    case (p)
      0:       return n;
      1:       return 15 - n;
      2:       return f;
      default: return (n % 2 == 1) ? 10 : 5;
    endcase
  endfunction

  task automatic model(input int p, input int f, input logic [15:0] mask, input logic zero,
                       output int e_err, output int e_first, output int e_pass);
    e_err = 0; e_first = 0;
    for (int n = 0; n < 16; n++) begin
      int w, r;
      w = model_pat(p, f, n);
      r = mask[n] ? (zero ? 0 : 15 - w) : w;
      if (r != w) begin
        if (e_err == 0) e_first = n;
        e_err++;
      end
    end
    e_pass = (e_err == 0) ? 1 : 0;
  endtask

  task automatic check_reset(input string tag);
    for (int g = 0; g < NI; g++)
      check($sformatf("%s inst%0d outputs", tag, g),
            int'({we[g], addr[g], din[g], busy[g], done[g], pass[g], errc[g], first[g]}), 0);
  endtask

  // One full test on all three builds; start may be re-pulsed while busy at edge restart_at.
  task automatic run_test(input string tag, input logic [1:0] pat, input logic [3:0] fv,
                          input logic [15:0] mask, input logic zero,
                          input int e_err, input int e_first, input int e_pass, input int restart_at);
    int done_edge [NI];
    int pulses    [NI];
    int wn0       [16];
    int bad;
    for (int i = 0; i < 16; i++) wn0[i] = gi[0].wn[i];
    for (int g = 0; g < NI; g++) begin done_edge[g] = -1; pulses[g] = 0; end
    bad_mask = mask; bad_zero = zero;
    @(negedge clk);
    pattern = pat; fill = fv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pattern = ~pat; fill = ~fv;
    for (int k = 1; k <= 40; k++) begin
      if (k == restart_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 1)  check({tag, " busy after accept"}, int'(busy[0]), 1);
      if (k == 34) check({tag, " busy after done"}, int'(busy[0]), 0);
      if (done[0] && done_edge[0] < 0) check({tag, " pass at done"}, int'(pass[0]), e_pass);
      for (int g = 0; g < NI; g++)
        if (done[g]) begin
          pulses[g]++;
          if (done_edge[g] < 0) done_edge[g] = k;
        end
    end
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s inst%0d done edge", tag, g), done_edge[g], 32 + lat_of(g));
      check($sformatf("%s inst%0d done pulses", tag, g), pulses[g], 1);
      check($sformatf("%s inst%0d err_cnt", tag, g), int'(errc[g]), e_err);
      check($sformatf("%s inst%0d first_err_addr", tag, g), int'(first[g]), e_first);
      check($sformatf("%s inst%0d pass", tag, g), int'(pass[g]), e_pass);
    end
    bad = 0;
    for (int a = 0; a < 16; a++)
      if ((gi[0].wn[a] - wn0[a] != 1) || (int'(gi[0].wlog[a]) != model_pat(pat, fv, a))) bad++;
    check({tag, " bad write addresses"}, bad, 0);
  endtask

  typedef struct {
    logic [1:0]  pat;
    logic [3:0]  fill;
    logic [15:0] mask;
    logic        zero;
    int          e_err;
    int          e_first;
    int          e_pass;
  } vec_t;

  vec_t vt [5];

  initial begin
    int e_err, e_first, e_pass;
    int d1 [NI];
    int d2 [NI];
    int np [NI];
    logic [1:0]  rp;
    logic [3:0]  rf;
    logic [15:0] rm;
    logic        rz;

    vt[0] = '{2'd0, 4'h0, 16'h0000, 1'b0, 0, 0, 1};
    vt[1] = '{2'd1, 4'h0, 16'h0000, 1'b0, 0, 0, 1};
    vt[2] = '{2'd2, 4'h9, 16'h0000, 1'b0, 0, 0, 1};
    vt[3] = '{2'd3, 4'h0, 16'h0020, 1'b1, 1, 5, 0};
    vt[4] = '{2'd0, 4'h0, 16'h1088, 1'b0, 3, 3, 0};

    rst_n = 1'b1; start = 1'b0; pattern = 2'd0; fill = 4'h0; bad_mask = 16'h0; bad_zero = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_test($sformatf("vec%0d", i), vt[i].pat, vt[i].fill, vt[i].mask, vt[i].zero,
               vt[i].e_err, vt[i].e_first, vt[i].e_pass, 0);

    run_test("restart while busy", 2'd2, 4'h6, 16'h0000, 1'b0, 0, 0, 1, 10);

    // Abort in the middle of READ.
    bad_mask = 16'h0;
    @(negedge clk);
    pattern = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("busy before abort", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_test("after abort", 2'd0, 4'h0, 16'h0000, 1'b0, 0, 0, 1, 0);

    // start held high across DONE->IDLE launches a back-to-back test.
    for (int g = 0; g < NI; g++) begin d1[g] = -1; d2[g] = -1; np[g] = 0; end
    @(negedge clk);
    pattern = 2'd1; start = 1'b1;
    for (int k = 0; k <= 85; k++) begin
      @(posedge clk); #1;
      if (k == 60) start = 1'b0;
      for (int g = 0; g < NI; g++)
        if (done[g]) begin
          np[g]++;
          if (d1[g] < 0) d1[g] = k; else if (d2[g] < 0) d2[g] = k;
        end
    end
    for (int g = 0; g < NI; g++) begin
      check($sformatf("held start inst%0d first done", g), d1[g], 32 + lat_of(g));
      check($sformatf("held start inst%0d second done", g), d2[g], 2 * (32 + lat_of(g)) + 2);
      check($sformatf("held start inst%0d pulses", g), np[g], 2);
    end

    for (int i = 0; i < 8; i++) begin
      rp = 2'($urandom_range(0, 3));
      rf = 4'($urandom);
      rm = (i == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
      rz = 1'($urandom);
      model(int'(rp), int'(rf), rm, rz, e_err, e_first, e_pass);
      run_test($sformatf("rand%0d", i), rp, rf, rm, rz, e_err, e_first, e_pass,
               (i % 2 == 1) ? $urandom_range(2, 30) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Memory built-in-self-test sequencer sitting directly upstream of the 16x4 single-port RAM (ram_init_v1).
- Owns the RAM's we/addr/din, consumes its dout.
- On start: writes a selectable pattern to every address, reads every address back and compares against expected data.
- Reports pass/fail, mismatch count and first failing address to the test controller.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 4, RAM data width.
- RD_LAT, 1, cycles from addr presented (we=0) to valid dout; legal 0..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin test; sampled only in IDLE.
- pattern  in  2  0=addr, 1=~addr, 2=fill_val constant, 3=checkerboard (5 on even addr, A on odd, truncated/extended to DATA_W).
- fill_val  in  DATA_W  constant used by pattern 2.
- we  out  1  RAM write enable.
- addr  out  ADDR_W  RAM address.
- din  out  DATA_W  RAM write data.
- dout  in  DATA_W  RAM read data.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse at end of test.
- pass  out  1  err_cnt==0; valid from done, held until next start.
- err_cnt  out  ADDR_W+1  number of mismatching reads, 0..DEPTH, no overflow possible.
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.

Behaviour:
- Reset (async, rst_n=0): state IDLE; we, addr, din, busy, done, pass, err_cnt, first_err_addr all 0; compare pipeline cleared.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE. All outputs registered.
- IDLE:
  - start=1 latches pattern and fill_val.
  - Clears err_cnt, pass and first_err_addr; enters WRITE with addr=0.
  - start=0 keeps we=0 and holds the previous results.
- WRITE:
  - we=1, addr=n, din=pattern(n) for n=0..DEPTH-1, one address per cycle.
  - After n=DEPTH-1: enter READ, addr=0, we=0.
- READ:
  - we=0, addr=n for n=0..DEPTH-1, one per cycle; din driven 0.
  - Expected value and address enter an RD_LAT-deep delay line.
  - After n=DEPTH-1: enter DRAIN if RD_LAT>0, else DONE.
- Compare:
  - Performed when a delay-line entry emerges, i.e. RD_LAT cycles after its addr was driven; with RD_LAT=0, compared in the same cycle.
  - Mismatch increments err_cnt.
  - If it is the first mismatch, capture its address into first_err_addr.
- DRAIN: RD_LAT cycles, no new addresses; addr holds DEPTH-1, we=0; pending compares complete.
- DONE:
  - One cycle: done=1, pass=(err_cnt==0) using the final count including the last compare.
  - Next state IDLE; busy drops with DONE exit.
- Latency: done is high in the cycle following clock edge 2*DEPTH+RD_LAT after start acceptance. DEPTH=16, RD_LAT=1: edge 33.
- Pattern/fill_val changes while busy are ignored (latched copies used).
- start while busy is ignored; start held high through DONE→IDLE starts a new test on the next IDLE cycle.
- rst_n asserted mid-test aborts immediately to reset values; no partial results are retained.
- addr wraps naturally at DEPTH-1; no write or read beyond DEPTH-1.

Test Plan:
- Reset, start pulse with pattern=0 and a good RAM -> 16 writes with din=addr 0..F, then 16 reads; done at edge 33; pass=1, err_cnt=0, first_err_addr=0.
- pattern=1 -> din sequence F,E,...,0 on writes; pass=1.
- pattern=2, fill_val=9 -> all writes din=9.
- Bench model forces dout=0 when reading addr 5 (pattern=3) -> err_cnt=1, first_err_addr=5, pass=0.
- Bench model corrupts addresses 3, 7 and C with pattern=0 -> err_cnt=3, first_err_addr=3, pass=0.
- rst_n low at edge 20 (during READ) -> all outputs 0 immediately and busy=0. A new start afterwards completes normally with pass=1.
- start asserted again while busy -> ignored; exactly one done pulse.
- RD_LAT=0 and RD_LAT=3 builds -> done at edges 32 and 35.
